// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX pacing FSM state encoding.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } uart_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO: same-edge status update; dout registered on pop.
// A push into a full FIFO and a pop from an empty FIFO are both ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [UART_DW-1:0] din,
  output logic [UART_DW-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [UART_DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  // Fullness is judged before any same-cycle pop, so a push at full is dropped.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers producer bytes and hands them one at a time to the UART transmitter,
// pulsing send_en 2 cycles after a pop decision and waiting for tx_done before the next byte.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  input  logic               tx_done,
  output logic [UART_DW-1:0] data_byte,
  output logic               send_en,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count,
  output logic               busy,
  output logic               overflow
);

  uart_state_t state_q;
  uart_state_t state_d;
  logic        pop;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (data_byte),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Pops only on entry to LOAD, so the FIFO is never read while empty.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // send_en is a registered copy of LOAD, giving a one-cycle pulse after data_byte settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      send_en  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      send_en <= (state_q == ST_LOAD);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign busy = (state_q == ST_LOAD) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_done;
  logic [7:0]    data_byte;
  logic          send_en;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          busy;
  logic          overflow;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .tx_done   (tx_done),
    .data_byte (data_byte),
    .send_en   (send_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: stored bytes, byte in flight, cycles since its pop.
  byte unsigned mq[$];
  bit           m_active;
  int           m_since;
  logic [7:0]   m_byte;
  bit           m_ovf;

  byte unsigned sent[$];
  byte unsigned hello[5];
  int           cyc_n = 0;
  int           last_send_cyc = 0;
  int           push_cyc;
  int           tx_timer = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d, input logic td, input logic r);
    bit was_full;
    bit done_ok;
    if (r) begin
      mq.delete();
      m_active = 1'b0;
      m_since  = 0;
      m_byte   = 8'h00;
      m_ovf    = 1'b0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    // A done pulse counts once the start pulse is issued or being issued.
    done_ok  = m_active && (m_since >= 1) && td;
    if (w && was_full) m_ovf = 1'b1;
    if (mq.size() > 0 && (!m_active || done_ok)) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_since  = 0;
    end else if (done_ok) begin
      m_active = 1'b0;
    end else if (m_active && m_since < 1000) begin
      m_since++;
    end
    if (w && !was_full) mq.push_back(d);
  endtask

  task automatic check_outputs();
    chk("count",     count,     mq.size());
    chk("empty",     empty,     mq.size() == 0);
    chk("full",      full,      mq.size() == DEPTH);
    chk("busy",      busy,      m_active);
    chk("send_en",   send_en,   m_active && m_since == 1);
    chk("overflow",  overflow,  m_ovf);
    chk("data_byte", data_byte, m_byte);
  endtask

  task automatic tick(input logic w, input logic [7:0] d, input logic td, input logic r);
    wr_en   = w;
    wr_data = d;
    tx_done = td;
    rst     = r;
    @(posedge clk);
    model_edge(w, d, td, r);
    cyc_n++;
    #1;
    check_outputs();
    if (send_en) begin
      sent.push_back(data_byte);
      last_send_cyc = cyc_n;
    end
  endtask

  // Emulated transmitter: tx_done dly+1 cycles after send_en; dly < 0 holds forever.
  task automatic step(input logic w, input logic [7:0] d, input int dly);
    logic td;
    td = (tx_timer == 0);
    tick(w, d, td, 1'b0);
    if (td) tx_timer = -1;
    else if (tx_timer > 0) tx_timer--;
    if (send_en) tx_timer = (dly < 0) ? -1 : dly;
  endtask

  task automatic do_reset();
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tx_timer = -1;
    sent.delete();
  endtask

  initial begin
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    // Single byte: latency and busy release.
    do_reset();
    step(1'b1, 8'h41, 99);
    push_cyc = cyc_n;
    for (int i = 0; i < 300 && !(sent.size() > 0 && !busy); i++) step(1'b0, 8'h00, 99);
    chk("s1_idle_after_done", busy, 1'b0);
    chk("s1_latency", last_send_cyc - push_cyc, 2);
    chk("s1_nsent", sent.size(), 1);
    chk("s1_byte", (sent.size() > 0) ? sent[0] : 8'hxx, 8'h41);

    // HELLO burst.
    sent.delete();
    for (int i = 0; i < 5; i++) step(1'b1, hello[i], 7);
    for (int i = 0; i < 300 && !(sent.size() == 5 && !busy); i++) step(1'b0, 8'h00, 7);
    chk("s2_nsent", sent.size(), 5);
    for (int i = 0; i < 5 && i < sent.size(); i++) chk("s2_order", sent[i], hello[i]);

    // Fill while held in WAIT, overflow, then push together with tx_done at full.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 8'h60 + 8'(i), -1);
    chk("s3_count16", count, 16);
    chk("s3_full", full, 1'b1);
    chk("s3_no_ovf_yet", overflow, 1'b0);
    step(1'b1, 8'hEE, -1);
    chk("s3_ovf", overflow, 1'b1);
    tick(1'b1, 8'hDD, 1'b1, 1'b0);
    chk("s4_count15", count, 15);
    chk("s4_ovf", overflow, 1'b1);
    for (int i = 0; i < 600 && !(empty && !busy); i++) step(1'b0, 8'h00, 3);
    chk("s3_nsent", sent.size(), 17);
    for (int i = 0; i < 17 && i < sent.size(); i++) chk("s3_order", sent[i], 8'h60 + 8'(i));

    // Reset during WAIT with 3 queued, then a late tx_done.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), -1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, -1);
    chk("s5_queued", count, 3);
    sent.delete();
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("s5_count", count, 0);
    chk("s5_data", data_byte, 8'h00);
    chk("s5_nsent", sent.size(), 0);

    // Spurious tx_done while idle and empty.
    for (int i = 0; i < 6; i++) tick(1'b0, 8'h00, i[0], 1'b0);
    chk("s6_nsent", sent.size(), 0);
    chk("s6_busy", busy, 1'b0);

    // Random traffic: heavy phase (overflows), then light phase (drains).
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < ((i < 1500) ? 45 : 8)) ? 1'b1 : 1'b0,
           8'($urandom), int'($urandom_range(0, 12)));
    end
    for (int i = 0; i < 800 && !(empty && !busy); i++) step(1'b0, 8'h00, 2);
    chk("s7_drained", empty && !busy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
